// File: rtl/accumulator_pkg.sv
// Shared types and encodings for the multi-lane accumulator.
package accumulator_pkg;

    // ACC: beats are being summed; HOLD: a finished result waits for the consumer.
    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } acc_state_e;

    // Arithmetic mode as seen on sat_en_i.
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/sat_adder_n.sv
// Combinational signed adder with selectable wrap or saturate behaviour.
// ovf_o flags signed overflow in wrap mode and clamping in saturate mode;
// both happen under exactly the same condition.
module sat_adder_n #(
    parameter int SIZE = 18
) (
    input  logic signed [SIZE-1:0] in_0_i,
    input  logic signed [SIZE-1:0] in_1_i,
    input  logic                   sat_en_i,
    output logic signed [SIZE-1:0] out_o,
    output logic                   ovf_o
);
    import accumulator_pkg::*;

    localparam logic [SIZE-1:0] MAX_V = {1'b0, {(SIZE-1){1'b1}}};
    localparam logic [SIZE-1:0] MIN_V = {1'b1, {(SIZE-1){1'b0}}};

    logic [SIZE:0] sum_wide;

    // Clamp a one-bit-wider sum back into SIZE bits; the extra sign bit tells
    // which rail was crossed.
    function automatic logic [SIZE-1:0] saturate(input logic [SIZE:0] wide);
        if (wide[SIZE] != wide[SIZE-1]) begin
            return wide[SIZE] ? MIN_V : MAX_V;
        end
        return wide[SIZE-1:0];
    endfunction

    // Sign-extended add, overflow detection and mode select.
    always_comb begin
        sum_wide = {in_0_i[SIZE-1], in_0_i} + {in_1_i[SIZE-1], in_1_i};
        ovf_o    = sum_wide[SIZE] ^ sum_wide[SIZE-1];
        out_o    = (sat_en_i == MODE_SAT) ? saturate(sum_wide) : sum_wide[SIZE-1:0];
    end

endmodule

// File: rtl/accumulator_n.sv
// Multi-lane signed accumulator with per-lane sticky overflow, beat limit,
// a one-entry result holding register and synchronous abort.
module accumulator_n #(
    parameter int SIZE      = 18,
    parameter int LANES     = 4,
    parameter int MAX_BEATS = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    sat_en_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [LANES*SIZE-1:0]   in_data_i,
    input  logic                    in_last_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [LANES*SIZE-1:0]   out_data_o,
    output logic [LANES-1:0]        out_ovf_o
);
    import accumulator_pkg::*;

    localparam int              DW       = LANES * SIZE;
    localparam int              CNT_W    = $clog2(MAX_BEATS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

    acc_state_e        state_q, state_d;
    logic [DW-1:0]     sum_q, sum_d;
    logic [LANES-1:0]  ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [DW-1:0]     out_data_q, out_data_d;
    logic [LANES-1:0]  out_ovf_q, out_ovf_d;

    logic [DW-1:0]     add_sum;
    logic [LANES-1:0]  add_ovf;
    logic              accept;
    logic              terminal;

    // One adder per lane: running sum plus the incoming operand.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        sat_adder_n #(
            .SIZE(SIZE)
        ) u_add (
            .in_0_i  (sum_q[k*SIZE +: SIZE]),
            .in_1_i  (in_data_i[k*SIZE +: SIZE]),
            .sat_en_i(sat_en_i),
            .out_o   (add_sum[k*SIZE +: SIZE]),
            .ovf_o   (add_ovf[k])
        );
    end

    // Ready is low while a result is pending, during an abort and in reset.
    assign in_ready_o = ~(out_valid_q | clear_i | rst_i);
    assign accept     = in_valid_i & in_ready_o;
    assign terminal   = in_last_i | (cnt_q == CNT_LAST);

    // Next-state: abort first, then accumulate or hand the result over.
    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;

        if (clear_i) begin
            state_d     = ACC;
            sum_d       = '0;
            ovf_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_ovf_d   = '0;
        end else begin
            case (state_q)
                ACC: begin
                    if (accept) begin
                        if (terminal) begin
                            // Result leaves through the holding register so the
                            // running sums can restart from zero immediately.
                            out_data_d  = add_sum;
                            out_ovf_d   = ovf_q | add_ovf;
                            out_valid_d = 1'b1;
                            state_d     = HOLD;
                            sum_d       = '0;
                            ovf_d       = '0;
                            cnt_d       = '0;
                        end else begin
                            sum_d = add_sum;
                            ovf_d = ovf_q | add_ovf;
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready_i) begin
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                        out_ovf_d   = '0;
                        state_d     = ACC;
                    end
                end
                default: begin
                    state_d = ACC;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ACC;
            sum_q       <= '0;
            ovf_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= '0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_ovf_o   = out_ovf_q;

endmodule

// File: tb/tb_accumulator_n.sv
// Scoreboard bench for accumulator_n (SIZE=8, LANES=2, MAX_BEATS=4).
module tb_accumulator_n;

    localparam int SIZE      = 8;
    localparam int LANES     = 2;
    localparam int MAX_BEATS = 4;
    localparam int DW        = SIZE * LANES;
    localparam int MAXV      = (1 << (SIZE - 1)) - 1;
    localparam int MINV      = -(1 << (SIZE - 1));

    logic            clk_i       = 1'b0;
    logic            rst_i       = 1'b1;
    logic            clear_i     = 1'b0;
    logic            sat_en_i    = 1'b0;
    logic            in_valid_i  = 1'b0;
    logic            in_last_i   = 1'b0;
    logic            out_ready_i = 1'b1;
    logic [DW-1:0]   in_data_i   = '0;
    logic            in_ready_o;
    logic            out_valid_o;
    logic [DW-1:0]   out_data_o;
    logic [LANES-1:0] out_ovf_o;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [DW-1:0]    data;
        logic [LANES-1:0] ovf;
    } res_t;

    res_t             exp_q[$];
    int               m_sum[LANES];
    logic [LANES-1:0] m_ovf;
    int               m_cnt;
    bit               m_hold;

    accumulator_n #(
        .SIZE(SIZE), .LANES(LANES), .MAX_BEATS(MAX_BEATS)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (clear_i),
        .sat_en_i   (sat_en_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_data_i  (in_data_i),
        .in_last_i  (in_last_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_data_o (out_data_o),
        .out_ovf_o  (out_ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_flush();
        for (int k = 0; k < LANES; k++) m_sum[k] = 0;
        m_ovf  = '0;
        m_cnt  = 0;
        m_hold = 0;
        exp_q.delete();
    endtask

    // Reference: integer sums per lane, clamped or folded back into range.
    task automatic model_beat();
        res_t r;
        for (int k = 0; k < LANES; k++) begin
            int x;
            int t;
            x = $signed(in_data_i[k*SIZE +: SIZE]);
            t = m_sum[k] + x;
            if (t > MAXV) begin
                m_ovf[k] = 1'b1;
                t = sat_en_i ? MAXV : t - (1 << SIZE);
            end else if (t < MINV) begin
                m_ovf[k] = 1'b1;
                t = sat_en_i ? MINV : t + (1 << SIZE);
            end
            m_sum[k] = t;
        end
        m_cnt++;
        if (in_last_i || m_cnt == MAX_BEATS) begin
            for (int k = 0; k < LANES; k++) r.data[k*SIZE +: SIZE] = SIZE'(m_sum[k]);
            r.ovf = m_ovf;
            exp_q.push_back(r);
            for (int k = 0; k < LANES; k++) m_sum[k] = 0;
            m_ovf  = '0;
            m_cnt  = 0;
            m_hold = 1;
        end
    endtask

    // Monitor: compares DUT outputs with the scoreboard, then advances the model.
    initial begin
        model_flush();
        forever begin
            @(negedge clk_i or posedge rst_i);
            if (rst_i) begin
                #1;
                chk("rst_valid", 32'(out_valid_o), 0);
                chk("rst_data", 32'(out_data_o), 0);
                chk("rst_ovf", 32'(out_ovf_o), 0);
                chk("rst_ready", 32'(in_ready_o), 0);
                model_flush();
            end else begin
                chk("valid", 32'(out_valid_o), 32'(m_hold));
                chk("in_ready", 32'(in_ready_o), 32'(!(m_hold || clear_i)));
                if (out_valid_o) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 32'(out_valid_o), 0);
                    end else begin
                        chk("data", 32'(out_data_o), 32'(exp_q[0].data));
                        chk("ovf", 32'(out_ovf_o), 32'(exp_q[0].ovf));
                    end
                end else begin
                    chk("idle_data", 32'(out_data_o), 0);
                    chk("idle_ovf", 32'(out_ovf_o), 0);
                end
                if (clear_i) begin
                    model_flush();
                end else if (m_hold) begin
                    if (out_ready_i) begin
                        m_hold = 0;
                        void'(exp_q.pop_front());
                    end
                end else if (in_valid_i) begin
                    model_beat();
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    // Present one beat and hold it until the DUT takes it.
    task automatic send(input int a, input int b, input bit last, input bit sat);
        bit ok;
        in_data_i  = {SIZE'(b), SIZE'(a)};
        in_last_i  = last;
        sat_en_i   = sat;
        in_valid_i = 1'b1;
        ok = 1'b0;
        for (int i = 0; !ok; i++) begin
            if (i > 50) begin
                $display("FAIL send_timeout: beat (%0d,%0d) not taken", a, b);
                $fatal(1, "beat timeout");
            end
            @(negedge clk_i);
            ok = in_ready_o;
            @(posedge clk_i);
            #1;
        end
    endtask

    initial begin
        cycles(2);
        rst_i = 1'b0;
        cycles(1);

        // Wrap: (10,-3) (20,-4) last (5,-1) -> (35,-8)
        send(10, -3, 0, 0); send(20, -4, 0, 0); send(5, -1, 1, 0); idle(); cycles(3);

        // Overflow in wrap on lane 0, clamp in saturate on lane 1
        send(100, 0, 0, 0); send(100, 0, 1, 0); idle(); cycles(2);
        send(0, -100, 0, 1); send(0, -100, 1, 1); idle(); cycles(2);

        // Beat limit: four beats without last, then a fresh single beat
        repeat (4) send(1, 1, 0, 0);
        send(2, 2, 1, 0); idle(); cycles(2);

        // Backpressure: pending result held for several cycles with a beat waiting
        out_ready_i = 1'b0;
        send(3, 4, 1, 0);
        fork
            begin
                cycles(6);
                out_ready_i = 1'b1;
            end
            send(9, 9, 1, 0);
        join
        idle(); cycles(3);

        // Clear mid-accumulation with a beat offered
        send(5, 5, 0, 0);
        in_data_i = {8'd50, 8'd50}; in_last_i = 1'b1; in_valid_i = 1'b1; clear_i = 1'b1;
        cycles(1);
        clear_i = 1'b0; idle(); cycles(1);
        send(7, 7, 1, 0); idle(); cycles(2);

        // Clear while a result is held
        out_ready_i = 1'b0;
        send(1, 2, 1, 0); idle(); cycles(1);
        in_data_i = {8'd50, 8'd50}; in_last_i = 1'b1; in_valid_i = 1'b1; clear_i = 1'b1;
        cycles(1);
        clear_i = 1'b0; idle(); out_ready_i = 1'b1; cycles(1);
        send(7, 7, 1, 0); idle(); cycles(2);

        // Asynchronous reset between edges while holding a result
        out_ready_i = 1'b0;
        send(5, 6, 1, 0); idle(); cycles(2);
        #1 rst_i = 1'b1;
        cycles(1);
        rst_i = 1'b0;
        out_ready_i = 1'b1;
        cycles(1);
        send(7, 7, 1, 0); idle(); cycles(2);

        // Randomized traffic, including mode changes, stalls and aborts
        repeat (500) begin
            in_valid_i  = ($urandom_range(0, 3) != 0);
            in_last_i   = ($urandom_range(0, 3) == 0);
            sat_en_i    = 1'($urandom_range(0, 1));
            in_data_i   = DW'($urandom);
            out_ready_i = ($urandom_range(0, 2) != 0);
            clear_i     = ($urandom_range(0, 39) == 0);
            cycles(1);
        end
        clear_i = 1'b0; idle(); out_ready_i = 1'b1;
        cycles(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/accumulator_n.md
ACCUMULATOR_N -- requirements
Module: accumulator_n

Interface
REQ-001 SIZE SHALL be a parameter, default 18: per-lane operand and result width, in bits, signed two's complement.
REQ-002 LANES SHALL be a parameter, default 4: the number of independent accumulation lanes.
REQ-003 MAX_BEATS SHALL be a parameter, default 256: the maximum number of beats per accumulation; legal range is 2 or more.
REQ-004 clk_i SHALL be an input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 rst_i SHALL be an input, 1 bit: reset, asynchronous and active-high.
REQ-006 clear_i SHALL be an input, 1 bit: synchronous abort, which discards the running sums and any pending result.
REQ-007 sat_en_i SHALL be an input, 1 bit: arithmetic mode, 1 = saturate, 0 = wrap; sampled on every accepted beat.
REQ-008 in_valid_i SHALL be an input, 1 bit: the input beat is valid.
REQ-009 in_ready_o SHALL be an output, 1 bit: the block can accept an input beat.
REQ-010 in_data_i SHALL be an input, LANES*SIZE bits: the operands; lane k occupies bits [k*SIZE +: SIZE].
REQ-011 in_last_i SHALL be an input, 1 bit: marks the final beat of an accumulation.
REQ-012 out_valid_o SHALL be an output, 1 bit: a result is available.
REQ-013 out_ready_i SHALL be an input, 1 bit: the consumer accepts the result.
REQ-014 out_data_o SHALL be an output, LANES*SIZE bits: the per-lane sums, in the same lane packing as in_data_i.
REQ-015 out_ovf_o SHALL be an output, LANES bits: per-lane sticky overflow flag for the delivered result.

Function
REQ-016 A beat SHALL be accepted in any cycle where in_valid_i = 1 and in_ready_o = 1.
REQ-017 in_ready_o SHALL equal the inverse of (out_valid_o OR clear_i); it is combinational.
REQ-018 The state machine SHALL have two states:
- ACC: accumulating beats.
- HOLD: a result is waiting to be taken.
REQ-019 The state machine SHALL leave reset in ACC with all sums zero.
REQ-020 In ACC, each accepted beat SHALL update every lane: sum_k <= op(sum_k, in_k), where op is a signed SIZE-bit add.
REQ-021 In wrap mode, op SHALL return the sum modulo 2^SIZE and SHALL set ovf_k if signed overflow occurred.
REQ-022 In saturate mode, op SHALL clamp the result to +(2^(SIZE-1)-1) or -2^(SIZE-1) and SHALL set ovf_k whenever clamping occurs.
REQ-023 The ovf_k flags SHALL be sticky for the whole accumulation.
REQ-024 A beat counter SHALL count accepted beats, with width $clog2(MAX_BEATS).
- A beat is terminal if in_last_i = 1, or if it is beat number MAX_BEATS, i.e. the counter equals MAX_BEATS-1.
REQ-025 When a terminal beat is accepted in cycle t:
- In cycle t+1, out_data_o SHALL hold the sums including that beat, out_ovf_o SHALL hold the flags including that beat, and out_valid_o SHALL be 1.
- The state SHALL become HOLD.
- The running sums, flags and counter SHALL return to zero.
REQ-026 In HOLD, out_data_o, out_ovf_o and out_valid_o SHALL remain stable until out_ready_i = 1.
REQ-027 When out_ready_i = 1 in HOLD, out_valid_o SHALL fall in the next cycle and the state SHALL return to ACC; in_ready_o rises in that same next cycle, so there is one bubble.
REQ-028 A single-beat accumulation (in_last_i = 1 on the first beat) SHALL deliver exactly that beat's operands, with ovf = 0.
REQ-029 When clear_i = 1, the block SHALL accept no beat (in_ready_o = 0).
- In the next cycle, the sums, flags and counter SHALL be 0, out_valid_o SHALL be 0 and the state SHALL be ACC.
- clear_i SHALL take priority over out_ready_i and in_valid_i.
REQ-030 out_data_o and out_ovf_o SHALL be 0 whenever out_valid_o = 0.

Reset
REQ-031 On rst_i = 1, the block SHALL force, asynchronously: state = ACC; sums, flags and counter = 0; out_valid_o = 0, out_data_o = 0, out_ovf_o = 0.
- While in reset, in_ready_o SHALL be 0.
- In the first cycle after reset is released, in_ready_o SHALL be 1.
REQ-032 Reset asserted mid-accumulation or in HOLD SHALL discard all partial and pending results.

Structure
REQ-033 A shared package accumulator_pkg SHALL hold:
- the state enum type acc_state_e;
- the mode encodings MODE_WRAP = 0 and MODE_SAT = 1.
REQ-034 The per-lane arithmetic SHALL be a sub-module sat_adder_n, which is purely combinational.
- Parameter: SIZE.
- Inputs: in_0_i, in_1_i, sat_en_i.
- Outputs: out_o, ovf_o.
- accumulator_n SHALL instantiate sat_adder_n LANES times.

Verification (SIZE = 8, LANES = 2, MAX_BEATS = 4)
REQ-035 Wrap test: beats (10,-3), (20,-4), then last (5,-1), with out_ready_i = 1 -> out_data = (35,-8), ovf = 00, out_valid for exactly 1 cycle, starting 1 cycle after the last beat.
REQ-036 Overflow test, two accumulations:
- Wrap mode, lane 0 beats 100 then last 100 -> 0xC8 (-56), ovf[0] = 1.
- Saturate mode, lane 1 beats -100 then last -100 -> -128, ovf[1] = 1.
REQ-037 MAX_BEATS test: four beats of (1,1) with in_last_i = 0 -> result (4,4) after the 4th beat; the counter restarts at 0.
REQ-038 Backpressure test: result pending and out_ready_i = 0 for 5 cycles while in_valid_i = 1 -> in_ready_o = 0, out_data stable, no beats lost; after the result is accepted, the next accumulation starts from 0.
REQ-039 Clear test: clear_i pulsed in mid-accumulation, and again in HOLD, each time with in_valid_i = 1 -> the beat is not accepted, out_valid_o = 0 next cycle, and the following accumulation (7,7) last -> (7,7).
REQ-040 Reset test: rst_i asserted asynchronously between clock edges during HOLD -> outputs are 0 immediately; in_ready_o = 1 in the first cycle after reset is released.
